hilo_muldiv_unit: RTL and testbench

- Writer end of the HI/LO register pair. Executes MULT/MULTU/DIV/DIVU iteratively and MTHI/MTLO in one cycle.
- Owns the architectural HI and LO registers.
- Sits beside the EX-stage ALU. Its hi_q/lo_q feed the MFHI/MFLO read and forwarding path; busy stalls the pipeline.

---
 rtl/hilo_muldiv_unit_pkg.sv | 27 ++
 rtl/hilo_muldiv_unit_iter_core.sv | 104 ++++++++++
 rtl/hilo_muldiv_unit.sv | 113 +++++++++++
 tb/tb_hilo_muldiv_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared function codes and FSM encoding for the HI/LO mul/div unit and the MFHI/MFLO bypass logic.
package hilo_muldiv_unit_pkg;

    localparam logic [5:0] FUNC_MFHI  = 6'b010000;
    localparam logic [5:0] FUNC_MTHI  = 6'b010001;
    localparam logic [5:0] FUNC_MFLO  = 6'b010010;
    localparam logic [5:0] FUNC_MTLO  = 6'b010011;
    localparam logic [5:0] FUNC_MULT  = 6'b011000;
    localparam logic [5:0] FUNC_MULTU = 6'b011001;
    localparam logic [5:0] FUNC_DIV   = 6'b011010;
    localparam logic [5:0] FUNC_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    function automatic logic is_mul(input logic [5:0] f);
        return (f == FUNC_MULT) || (f == FUNC_MULTU);
    endfunction

    function automatic logic is_div(input logic [5:0] f);
        return (f == FUNC_DIV) || (f == FUNC_DIVU);
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_iter_core.sv
// Iterative mul/div datapath: shared 64-bit accumulator, shift-add multiply,
// restoring divide, iteration counter and final sign correction.
module muldiv_iter_core
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int CNT_W = $clog2(ITER);

    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   orig_a;
    logic               div_mode;
    logic               neg_q;
    logic               neg_r;
    logic               div0;

    logic               sgn_op;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + 1'b1;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + 1'b1;
    endfunction

    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? neg_w(v) : v;
    endfunction

    assign sgn_op = (func == FUNC_MULT) || (func == FUNC_DIV);
    assign last   = (cnt == CNT_W'(ITER - 1));

    // Multiply: multiplier sits in acc low half and is consumed LSB first.
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? op_b : '0)};
    // Divide: acc = {remainder, dividend/quotient}, dividend bits shift out the top.
    assign div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_ge    = (div_trial >= {1'b0, op_b});
    assign div_diff  = div_trial[WIDTH-1:0] - op_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            div_mode <= is_div(func);
            neg_q    <= sgn_op && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r    <= sgn_op && a[WIDTH-1];
            div0     <= (b == '0);
            orig_a   <= a;
            acc      <= is_div(func) ? {{WIDTH{1'b0}}, mag(a, sgn_op)} : {{WIDTH{1'b0}}, mag(b, sgn_op)};
            op_b     <= is_div(func) ? mag(b, sgn_op) : mag(a, sgn_op);
        end else if (step) begin
            if (div_mode) begin
                acc <= div_ge ? {div_diff, acc[WIDTH-2:0], 1'b1}
                              : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end else begin
                acc <= {mul_sum, acc[WIDTH-1:1]};
            end
        end
    end

    // Sign fix: 0x80000000 / -1 wraps back to 0x80000000 through the negation.
    always_comb begin
        res_hi = acc[2*WIDTH-1:WIDTH];
        res_lo = acc[WIDTH-1:0];
        if (!div_mode) begin
            {res_hi, res_lo} = neg_q ? neg_2w(acc) : acc;
        end else if (div0) begin
            res_hi = orig_a;
            res_lo = '1;
        end else begin
            res_hi = neg_r ? neg_w(acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
            res_lo = neg_q ? neg_w(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register owner: FSM, MTHI/MTLO writes, flush handling around muldiv_iter_core.
// Optional HILO_FAST_MUL_EN: single-cycle combinational MULT/MULTU written at the start edge.
module hilo_muldiv_unit
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       func_ex,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_q,
    output logic [WIDTH-1:0] lo_q
);

    state_e           state, state_nxt;
    logic             accept;
    logic             iter_op;
    logic             core_last;
    logic [WIDTH-1:0] core_hi;
    logic [WIDTH-1:0] core_lo;

`ifdef HILO_FAST_MUL_EN
    logic signed [2*WIDTH-1:0] mul_a, mul_b, mul_p;
    logic                      mul_sx;

    always_comb begin
        mul_sx = (func_ex == FUNC_MULT);
        mul_a  = {{WIDTH{mul_sx & rs_val[WIDTH-1]}}, rs_val};
        mul_b  = {{WIDTH{mul_sx & rt_val[WIDTH-1]}}, rt_val};
        mul_p  = mul_a * mul_b;
    end

    assign iter_op = is_div(func_ex);
`else
    assign iter_op = is_div(func_ex) || is_mul(func_ex);
`endif

    assign accept = (state == ST_IDLE) && start && !flush;
    assign busy   = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept && iter_op) state_nxt = ST_CALC;
            ST_CALC: begin
                if (flush)          state_nxt = ST_IDLE;
                else if (core_last) state_nxt = ST_FIX;
            end
            ST_FIX:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    muldiv_iter_core #(
        .WIDTH (WIDTH),
        .ITER  (ITER)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (accept && iter_op),
        .step   (state == ST_CALC),
        .func   (func_ex),
        .a      (rs_val),
        .b      (rt_val),
        .last   (core_last),
        .res_hi (core_hi),
        .res_lo (core_lo)
    );

    // A flush in FIX drops the result: HI/LO keep their pre-operation values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == ST_FIX && !flush) begin
                hi_q <= core_hi;
                lo_q <= core_lo;
                done <= 1'b1;
            end else if (accept) begin
                if (func_ex == FUNC_MTHI) begin
                    hi_q <= rs_val;
                end else if (func_ex == FUNC_MTLO) begin
                    lo_q <= rs_val;
                end
`ifdef HILO_FAST_MUL_EN
                else if (is_mul(func_ex)) begin
                    {hi_q, lo_q} <= mul_p;
                    done         <= 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit (default build, iterative multiply).
module tb_hilo_muldiv_unit;
    import hilo_muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  func_ex = 6'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    int          tests = 0;
    int          fails = 0;
    int          done_seen = 0;
    int          bcyc;
    logic [63:0] exp_q[$];

    hilo_muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .func_ex (func_ex),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .hi_q    (hi_q),
        .lo_q    (lo_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("result_hi", hi_q, e[63:32]);
                check("result_lo", lo_q, e[31:0]);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the start edge.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        start   = 1'b1;
        func_ex = f;
        rs_val  = a;
        rt_val  = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts busy cycles, returns at the first negedge with busy low.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            cycles++;
        end
        if (busy) check("busy_timeout", 32'(busy), 32'd0);
    endtask

    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] expv);
        @(posedge clk);
        #1;
        exp_q.push_back(expv);
        issue(f, a, b);
        wait_idle(bcyc);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_hi", hi_q, 32'd0);
        check("rst_lo", lo_q, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        run_op(FUNC_MULT, 32'hFFFF_FFFF, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFE});
        check("mult_busy_cycles", 32'(bcyc), 32'd33);
        run_op(FUNC_MULTU, 32'hFFFF_FFFF, 32'd2, {32'h0000_0001, 32'hFFFF_FFFE});
        check("multu_busy_cycles", 32'(bcyc), 32'd33);
        run_op(FUNC_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op(FUNC_DIVU, 32'd100, 32'd0, {32'h0000_0064, 32'hFFFF_FFFF});
        check("div0_busy_cycles", 32'(bcyc), 32'd33);
        run_op(FUNC_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000});
        run_op(FUNC_DIV, 32'hFFFF_FFF9, 32'd0, {32'hFFFF_FFF9, 32'hFFFF_FFFF});
        run_op(FUNC_DIVU, 32'd100, 32'd7, {32'h0000_0002, 32'h0000_000E});

        // MTHI then MTLO back to back
        @(posedge clk);
        #1;
        start = 1'b1; func_ex = FUNC_MTHI; rs_val = 32'h1234_5678;
        @(posedge clk);
        #1;
        check("mthi_hi", hi_q, 32'h1234_5678);
        check("mthi_busy", 32'(busy), 32'd0);
        func_ex = FUNC_MTLO; rs_val = 32'hCAFE_0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("mtlo_lo", lo_q, 32'hCAFE_0000);
        check("mtlo_hi", hi_q, 32'h1234_5678);
        check("mtlo_busy", 32'(busy), 32'd0);

        // DIV flushed at cycle 10
        issue(FUNC_DIV, 32'd1000, 32'd3);
        check("flush_busy_before", 32'(busy), 32'd1);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check("flush_hi", hi_q, 32'h1234_5678);
        check("flush_lo", lo_q, 32'hCAFE_0000);

        // flush and start together in IDLE
        start = 1'b1; flush = 1'b1; func_ex = FUNC_MTHI; rs_val = 32'hFFFF_0000;
        @(posedge clk);
        #1;
        func_ex = FUNC_DIVU;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start_hi", hi_q, 32'h1234_5678);
        check("flush_start_busy", 32'(busy), 32'd0);

        // unknown function code
        issue(6'b100000, 32'hAAAA_AAAA, 32'd5);
        check("unknown_busy", 32'(busy), 32'd0);
        check("unknown_hi", hi_q, 32'h1234_5678);
        check("unknown_lo", lo_q, 32'hCAFE_0000);

        // async reset between edges mid-CALC
        issue(FUNC_MULTU, 32'd77, 32'd99);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_hi", hi_q, 32'd0);
        check("arst_lo", lo_q, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // MULTU 3*5 with an MTHI issued while busy, which must be ignored
        exp_q.push_back({32'd0, 32'd15});
        issue(FUNC_MULTU, 32'd3, 32'd5);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; func_ex = FUNC_MTHI; rs_val = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 start = 1'b0;
        check("mthi_while_busy", hi_q, 32'd0);
        wait_idle(bcyc);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(done_seen), 32'd8);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
